// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN          - datapath width
//   NOP_INSTR     - instruction presented to decode out of reset (addi x0,x0,0)
//   fetch_entry_t - one buffered fetch result {instr, pc}
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/grant + in-order response,
// branch redirect, and the valid/ready handshake towards decode.
//   master : fetch_unit side (drives imem_req/imem_addr and the id_* outputs)
//   slave  : memory/decode/branch side
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both fetched entries and issued-PC tags.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata at tail
//   pop      : advance head
//   flush    : empty the FIFO (wins over push/pop)
//   rdata    : head entry (storage reset to RST_VAL so the head is defined out of reset)
//   count    : number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int unsigned       DEPTH   = 2,
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction
// memory, buffers in-order responses and hands them to decode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_if.master
//              imem_req/imem_addr/imem_gnt      request channel
//              imem_rvalid/imem_rdata           in-order response channel
//              redirect/redirect_pc             taken branch/jump, flushes in-flight work
//              id_valid/id_ready/id_instr/id_pc decode handshake
// Parameters: RESET_PC (PC after reset), DEPTH (FIFO entries = max outstanding, pow2 2..8)
// Build option: FETCH_BYPASS_EN - a kept response reaches decode combinationally when
//               the entry FIFO is empty; otherwise outputs come straight from the FIFO head.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] live;        // outstanding requests whose words are kept
    logic [CNT_W-1:0] drop;        // outstanding requests whose words are discarded
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] tag_count;
    logic [XLEN-1:0]  tag_head;
    fetch_entry_t     head;
    fetch_entry_t     rsp_entry;
    logic             grant;
    logic             kept;
    logic             push_entry;
    logic             pop_entry;

    // Issue throttle: leave room for every kept word and bound total outstanding
    assign bus.imem_req  = ~rst
                         & ((fifo_count + live) < CNT_W'(DEPTH))
                         & ((live + drop) < CNT_W'(DEPTH));
    assign bus.imem_addr = pc;

    assign grant     = bus.imem_req & bus.imem_gnt;
    assign kept      = ~rst & bus.imem_rvalid & ~bus.redirect & (drop == '0);
    assign rsp_entry = '{instr: bus.imem_rdata, pc: tag_head};
    assign pop_entry = bus.id_ready & (fifo_count != '0) & ~bus.redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // Empty FIFO: the arriving word goes straight to decode; stored only if decode stalls
    assign bypass       = kept & (fifo_count == '0);
    assign bus.id_valid = (fifo_count != '0) | bypass;
    assign bus.id_instr = bypass ? bus.imem_rdata : head.instr;
    assign bus.id_pc    = bypass ? tag_head       : head.pc;
    assign push_entry   = kept & ~(bypass & bus.id_ready);
`else
    assign bus.id_valid = (fifo_count != '0);
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;
    assign push_entry   = kept;
`endif

    // Addresses of kept requests, consumed in order as their words return
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (XLEN),
        .RST_VAL (RESET_PC)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (kept),
        .flush (bus.redirect),
        .wdata (pc),
        .rdata (tag_head),
        .count (tag_count)
    );

    // Fetched {instr, pc} entries waiting for decode; reset head reads as NOP @ RESET_PC
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (ENT_W),
        .RST_VAL ({NOP_INSTR, RESET_PC})
    ) u_entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_entry),
        .pop   (pop_entry),
        .flush (bus.redirect),
        .wdata (rsp_entry),
        .rdata (head),
        .count (fifo_count)
    );

    // PC and outstanding-request bookkeeping; a redirect turns all in-flight work into drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= RESET_PC;
            live <= '0;
            drop <= '0;
        end else if (bus.redirect) begin
            pc   <= bus.redirect_pc & ~XLEN'(3);
            live <= '0;
            drop <= drop + live + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
        end else begin
            if (grant) begin
                pc <= pc + XLEN'(4);
            end
            live <= live + CNT_W'(grant) - CNT_W'(kept);
            drop <= drop - CNT_W'(bus.imem_rvalid & (drop != '0));
        end
    end

    // A response with nothing outstanding is a memory protocol violation
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> ((live != '0) || (drop != '0)));

    // One tag is held per kept outstanding request
    a_tag_tracks_live: assert property (@(posedge clk) disable iff (rst)
        tag_count == live);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_CYC = 1;
`else
    localparam int FIRST_CYC = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: outstanding memory requests and words buffered for decode
    typedef struct { logic [31:0] addr; bit keep; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    req_t        mem_q[$];
    ent_t        buf_q[$];
    logic [31:0] seen_q[$];
    int          seen_cyc[$];
    logic [31:0] exp_pc;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rsp_pct = 100;
    bit          hold = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a ^ 32'hDEAD_0000) + {a[15:0], a[31:16]};
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].keep) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt);
        bit   rsp;
        bit   ev;
        bit   byp;
        bit   exp_req;
        req_t r;
        ent_t h;
        rsp = !hold && mem_q.size() > 0 && mem_q[0].due <= cyc &&
              ($urandom_range(99) < rsp_pct);
        bus.imem_gnt    = gnt;
        bus.id_ready    = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = rsp ? instr_of(mem_q[0].addr) : $urandom();
        #2;
        exp_req = ((buf_q.size() + live_cnt()) < DEPTH) && (mem_q.size() < DEPTH);
        ev  = buf_q.size() != 0;
        byp = 0;
`ifdef FETCH_BYPASS_EN
        if (!ev && rsp && mem_q[0].keep && !redir) begin
            ev  = 1;
            byp = 1;
        end
`endif
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        chk("imem_addr", bus.imem_addr, exp_pc);
        chk("id_valid", 32'(bus.id_valid), 32'(ev));
        if (ev) begin
            if (byp) h = '{instr_of(mem_q[0].addr), mem_q[0].addr};
            else     h = buf_q[0];
            chk("id_pc", bus.id_pc, h.pc);
            chk("id_instr", bus.id_instr, h.instr);
        end
        if (bus.id_valid && rdy && !redir) begin
            seen_q.push_back(bus.id_pc);
            seen_cyc.push_back(cyc);
        end
        if (rsp) r = mem_q.pop_front();
        if (redir) begin
            buf_q.delete();
            foreach (mem_q[i]) mem_q[i].keep = 0;
            if (exp_req && gnt) mem_q.push_back('{exp_pc, 0, cyc + 1});
            exp_pc = tgt & ~32'h3;
        end else begin
            if (ev && rdy && !byp) void'(buf_q.pop_front());
            if (rsp && r.keep && !(byp && rdy)) buf_q.push_back('{instr_of(r.addr), r.addr});
            if (exp_req && gnt) begin
                mem_q.push_back('{exp_pc, 1, cyc + 1});
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.imem_gnt    = 0;
        bus.imem_rvalid = 0;
        bus.imem_rdata  = '0;
        bus.redirect    = 0;
        bus.redirect_pc = '0;
        bus.id_ready    = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_imem_req"},  32'(bus.imem_req), 32'd0);
        chk({tag, "_imem_addr"}, bus.imem_addr, RST_PC);
        chk({tag, "_id_valid"},  32'(bus.id_valid), 32'd0);
        chk({tag, "_id_instr"},  bus.id_instr, NOP_INSTR);
        chk({tag, "_id_pc"},     bus.id_pc, RST_PC);
    endtask

    initial begin
        logic [31:0] exp_first;
        int          n;

        // Reset values
        idle_inputs();
        exp_pc = RST_PC;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst = 0;
        cyc = 0;

        // Streaming from RESET_PC with single-cycle memory
        repeat (6) step(1, 1, 0, '0);
        chk("stream_count_ok", 32'(seen_q.size() >= 3), 32'd1);
        if (seen_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("stream_pc", seen_q[i], RST_PC + 32'(4 * i));
                chk("stream_cycle", 32'(seen_cyc[i]), 32'(FIRST_CYC + i));
            end
        end

        // Decode stall: issue stops at the buffer limit, head held, nothing lost after release
        exp_first = buf_q[0].pc;
        seen_q.delete();
        repeat (5) step(1, 0, 0, '0);
        chk("stall_req_off", 32'(bus.imem_req), 32'd0);
        chk("stall_hold_pc", bus.id_pc, exp_first);
        chk("stall_hold_instr", bus.id_instr, instr_of(exp_first));
        repeat (8) step(1, 1, 0, '0);
        chk("release_count_ok", 32'(seen_q.size() >= 6), 32'd1);
        if (seen_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("release_seq", seen_q[i], exp_first + 32'(4 * i));
        end

        // Drain, then redirect with two requests outstanding
        n = 0;
        while ((mem_q.size() != 0 || buf_q.size() != 0) && n < 50) begin
            step(0, 1, 0, '0);
            n++;
        end
        chk("drain_timeout", 32'(n < 50), 32'd1);
        hold = 1;
        repeat (2) step(1, 1, 0, '0);
        step(0, 1, 1, 32'h0000_2003);
        chk("redir_addr", bus.imem_addr, 32'h0000_2000);
        hold = 0;
        seen_q.delete();
        repeat (10) step(1, 1, 0, '0);
        chk("redir_count_ok", 32'(seen_q.size() >= 2), 32'd1);
        if (seen_q.size() >= 2) begin
            chk("redir_first_pc", seen_q[0], 32'h0000_2000);
            chk("redir_second_pc", seen_q[1], 32'h0000_2004);
        end

        // Response, grant and redirect all in one cycle
        repeat (4) step(1, 1, 0, '0);
        chk("rr_req_high", 32'(bus.imem_req), 32'd1);
        seen_q.delete();
        step(1, 1, 1, 32'h0000_3000);
        repeat (10) step(1, 1, 0, '0);
        chk("rr_count_ok", 32'(seen_q.size() >= 1), 32'd1);
        if (seen_q.size() >= 1) chk("rr_first_pc", seen_q[0], 32'h0000_3000);

        // PC wrap at the top of the address space
        seen_q.delete();
        step(1, 1, 1, 32'hFFFF_FFF9);
        repeat (10) step(1, 1, 0, '0);
        chk("wrap_count_ok", 32'(seen_q.size() >= 3), 32'd1);
        if (seen_q.size() >= 3) begin
            chk("wrap_pc0", seen_q[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", seen_q[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", seen_q[2], 32'h0000_0000);
        end

        // Random traffic: grant gaps, variable latency, decode stalls, redirects
        rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            bit redir;
            redir = ($urandom_range(39) == 0);
            step(($urandom_range(3) != 0), ($urandom_range(2) != 0), redir,
                 ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom());
        end
        rsp_pct = 100;

        // Asynchronous reset mid-stream with the entry buffer full
        repeat (12) step(1, 0, 0, '0);
        chk("pre_rst_valid", 32'(bus.id_valid), 32'd1);
        #2;
        rst = 1;
        idle_inputs();
        #1;
        chk_reset_state("async_rst");
        mem_q.delete();
        buf_q.delete();
        seen_q.delete();
        seen_cyc.delete();
        exp_pc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("held_rst");
        rst = 0;
        cyc = 0;
        repeat (6) step(1, 1, 0, '0);
        chk("restart_count_ok", 32'(seen_q.size() >= 2), 32'd1);
        if (seen_q.size() >= 2) begin
            chk("restart_pc0", seen_q[0], RST_PC);
            chk("restart_pc1", seen_q[1], RST_PC + 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
